// File: rtl/traffic_ctrl_actuated.sv
// traffic_ctrl_actuated: tick-timed junction controller with all-red clearance, actuated side phase and failsafe flash.
module traffic_ctrl_actuated #(
  parameter int CNT_W      = 8,
  parameter int T_M_GREEN  = 7,
  parameter int T_MT_GREEN = 5,
  parameter int T_S_GREEN  = 3,
  parameter int T_YELLOW   = 2,
  parameter int T_ALLRED   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             s_req,
  input  logic             flash_req,
  output logic [2:0]       light_M1,
  output logic [2:0]       light_M2,
  output logic [2:0]       light_MT,
  output logic [2:0]       light_S,
  output logic [3:0]       phase,
  output logic             s_pend,
  output logic [CNT_W-1:0] remain
);
  typedef enum logic [3:0] {
    M_GREEN  = 4'd0,
    M2_YEL   = 4'd1,
    MT_GREEN = 4'd2,
    MT_YEL   = 4'd3,
    ALL_RED1 = 4'd4,
    S_GREEN  = 4'd5,
    S_YEL    = 4'd6,
    ALL_RED2 = 4'd7,
    FLASH    = 4'd8
  } state_t;

  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

  state_t           state_q, state_d, nxt;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             s_pend_q, s_pend_d, tog_q, tog_d;
  logic [11:0]      lamps_q, lamps_d;

  function automatic logic [CNT_W-1:0] load(input state_t s);
    case (s)
      M_GREEN:                  return CNT_W'(T_M_GREEN - 1);
      MT_GREEN:                 return CNT_W'(T_MT_GREEN - 1);
      S_GREEN:                  return CNT_W'(T_S_GREEN - 1);
      M2_YEL, MT_YEL, S_YEL:    return CNT_W'(T_YELLOW - 1);
      ALL_RED1, ALL_RED2:       return CNT_W'(T_ALLRED - 1);
      default:                  return '0;
    endcase
  endfunction

  // lamp order {M1, M2, MT, S}
  function automatic logic [11:0] lamps(input state_t s, input logic t);
    case (s)
      M_GREEN:  return 12'b001_001_100_100;
      M2_YEL:   return 12'b001_010_100_100;
      MT_GREEN: return 12'b001_100_001_100;
      MT_YEL:   return 12'b010_100_010_100;
      S_GREEN:  return 12'b100_100_100_001;
      S_YEL:    return 12'b100_100_100_010;
      FLASH:    return t ? 12'b010_010_100_100 : 12'b000_000_000_000;
      default:  return ALL_RED;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      M_GREEN:  nxt = M2_YEL;
      M2_YEL:   nxt = MT_GREEN;
      MT_GREEN: nxt = MT_YEL;
      MT_YEL:   nxt = ALL_RED1;
      ALL_RED1: nxt = flash_req ? FLASH : s_pend_q ? S_GREEN : M_GREEN;
      S_GREEN:  nxt = S_YEL;
      S_YEL:    nxt = ALL_RED2;
      ALL_RED2: nxt = flash_req ? FLASH : M_GREEN;
      default:  nxt = ALL_RED2;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    tog_d    = tog_q;
    s_pend_d = s_pend_q | (s_req && state_q != S_GREEN && state_q != S_YEL);
    if (state_q > FLASH) begin
      state_d  = ALL_RED2;
      remain_d = load(ALL_RED2);
    end else if (tick) begin
      if (state_q == FLASH) begin
        tog_d = ~tog_q;
        if (!flash_req) begin
          state_d  = ALL_RED2;
          remain_d = load(ALL_RED2);
        end
      end else if (remain_q != '0) begin
        remain_d = remain_q - CNT_W'(1);
      end else begin
        state_d  = nxt;
        remain_d = load(nxt);
        tog_d    = 1'b1;
      end
    end
    // serving the side phase consumes the demand, even one arriving this cycle
    if (state_d == S_GREEN && state_q != S_GREEN) s_pend_d = 1'b0;
    lamps_d = lamps(state_d, tog_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALL_RED2;
      remain_q <= CNT_W'(T_ALLRED - 1);
      s_pend_q <= 1'b0;
      tog_q    <= 1'b1;
      lamps_q  <= ALL_RED;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      s_pend_q <= s_pend_d;
      tog_q    <= tog_d;
      lamps_q  <= lamps_d;
    end
  end

  assign {light_M1, light_M2, light_MT, light_S} = lamps_q;
  assign phase  = state_q;
  assign s_pend = s_pend_q;
  assign remain = remain_q;
endmodule

// File: tb/tb_traffic_ctrl_actuated.sv
// tb_traffic_ctrl_actuated: directed and random stimulus against a phase/elapsed-tick reference model.
module tb_traffic_ctrl_actuated;
  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, s_req = 1'b0, flash_req = 1'b0;
  logic [2:0] l_m1, l_m2, l_mt, l_s;
  logic [3:0] phase;
  logic       s_pend;
  logic [7:0] remain;

  traffic_ctrl_actuated dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .s_req(s_req), .flash_req(flash_req),
    .light_M1(l_m1), .light_M2(l_m2), .light_MT(l_mt), .light_S(l_s),
    .phase(phase), .s_pend(s_pend), .remain(remain)
  );

  always #5 clk = ~clk;

  localparam int          DUR  [8] = '{7, 2, 5, 2, 1, 3, 2, 1};
  localparam logic [11:0] LAMP [8] = '{12'b001_001_100_100, 12'b001_010_100_100,
                                       12'b001_100_001_100, 12'b010_100_010_100,
                                       12'b100_100_100_100, 12'b100_100_100_001,
                                       12'b100_100_100_010, 12'b100_100_100_100};

  int          n_cmp = 0, n_bad = 0;
  int          m_ph, m_el, tick_cnt;
  bit          m_pend, m_tog, fl;
  logic [11:0] prev_l;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_ph = 7; m_el = 0; m_pend = 0; m_tog = 1;
  endfunction

  // model: phase plus ticks elapsed in it; a phase ends once elapsed reaches its duration
  function automatic void m_step(bit t, bit s, bit f);
    bit np;
    int nx;
    np = m_pend | (s && m_ph != 5 && m_ph != 6);
    if (t) begin
      if (m_ph == 8) begin
        m_tog = !m_tog;
        if (!f) begin m_ph = 7; m_el = 0; end
      end else begin
        m_el++;
        if (m_el == DUR[m_ph]) begin
          if (m_ph == 4)      nx = f ? 8 : (m_pend ? 5 : 0);
          else if (m_ph == 7) nx = f ? 8 : 0;
          else                nx = m_ph + 1;
          m_ph = nx; m_el = 0; m_tog = 1;
          if (nx == 5) np = 0;
        end
      end
    end
    m_pend = np;
  endfunction

  task automatic compare_all();
    logic [11:0] cur, exp_l;
    int          exp_r;
    cur   = {l_m1, l_m2, l_mt, l_s};
    exp_l = (m_ph == 8) ? (m_tog ? 12'b010_010_100_100 : 12'b0) : LAMP[m_ph];
    exp_r = (m_ph == 8) ? 0 : DUR[m_ph] - 1 - m_el;
    chk("phase", phase, m_ph);
    chk("lights", cur, exp_l);
    chk("remain", remain, exp_r);
    chk("s_pend", s_pend, m_pend);
    chk("excl_green", ((l_m2 == 3'b001) + (l_mt == 3'b001) + (l_s == 3'b001)) <= 1, 1);
    if (l_s == 3'b001) chk("s_mains_red", {l_m1, l_m2, l_mt}, 9'b100_100_100);
    for (int i = 0; i < 4; i++)
      if (prev_l[i*3 +: 3] == 3'b001 && cur[i*3 +: 3] != 3'b001)
        chk("green_to_yel", cur[i*3 +: 3], 3'b010);
    prev_l = cur;
  endtask

  task automatic cyc(input bit t, input bit s, input bit f);
    int old;
    tick = t; s_req = s; flash_req = f;
    old = phase;
    @(posedge clk);
    if (!rst_n) m_reset(); else m_step(t, s, f);
    #1;
    if (!rst_n) tick_cnt = 0;
    else begin
      if (t && old < 8) tick_cnt++;
      if (phase != old) begin
        if (old < 8) chk("duration", tick_cnt, DUR[old]);
        tick_cnt = 0;
      end
    end
    compare_all();
  endtask

  initial begin
    m_reset();
    tick_cnt = 0;
    prev_l = 12'b100_100_100_100;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) cyc(1, 0, 0);
    // side demand pulse during MT_GREEN
    for (int i = 0; i < 40 && m_ph != 2; i++) cyc(1, 0, 0);
    if (m_ph != 2) chk("wait_mt_green", m_ph, 2);
    cyc(1, 1, 0);
    for (int i = 0; i < 30; i++) cyc(1, 0, 0);
    // slow tick
    for (int i = 0; i < 80; i++) cyc(i % 4 == 0, 0, 0);
    // flash request raised mid M_GREEN
    for (int i = 0; i < 40 && m_ph != 0; i++) cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 0, 1);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0);
    // asynchronous reset during S_GREEN
    cyc(1, 1, 0);
    for (int i = 0; i < 60 && m_ph != 5; i++) cyc(1, 0, 0);
    if (m_ph != 5) chk("wait_s_green", m_ph, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_lights", {l_m1, l_m2, l_mt, l_s}, 12'b100_100_100_100);
    chk("async_s_pend", s_pend, 0);
    chk("async_phase", phase, 7);
    m_reset();
    prev_l = 12'b100_100_100_100;
    tick_cnt = 0;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0);
    // random soak
    fl = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 299) == 0) fl = !fl;
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, fl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl_actuated.md
Name: traffic_ctrl_actuated

Overview:
- Parametrised successor of the fixed-timer 3-way junction controller. Drives four approaches: main M1, main M2, main turn MT, and side road S.
- Durations are parameters counted in tick strobes, not raw clocks.
- Adds all-red clearance phases, a demand-actuated side phase that is skipped when no vehicle is waiting, and a flashing failsafe mode.
- Sits between the 1 Hz tick generator and the lamp-driver outputs.

Parameters:
- CNT_W, 8: phase-counter width. Every T_* must be ≥1 and ≤ 2^CNT_W.
- T_M_GREEN, 7: ticks in M_GREEN.
- T_MT_GREEN, 5: ticks in MT_GREEN.
- T_S_GREEN, 3: ticks in S_GREEN.
- T_YELLOW, 2: ticks in every yellow state.
- T_ALLRED, 1: ticks in every all-red state.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle timing strobe; phase counters advance only on cycles with tick=1
- s_req  in  1  side-road vehicle detector, level or pulse
- flash_req  in  1  failsafe flash request, level
- light_M1, light_M2, light_MT, light_S  out  3 each  lamp code: 001 green, 010 yellow, 100 red, 000 dark
- phase  out  4  current state code
- s_pend  out  1  latched side demand
- remain  out  CNT_W  ticks left in the current state minus 1 (the counter value)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ALL_RED2, remain=T_ALLRED-1, s_pend=0, flash toggle=1.
  - All four lights=100.
  - phase=7.
- State codes and lamps (M1/M2/MT/S):
  - M_GREEN=0: 001/001/100/100
  - M2_YEL=1: 001/010/100/100
  - MT_GREEN=2: 001/100/001/100
  - MT_YEL=3: 010/100/010/100
  - ALL_RED1=4: 100/100/100/100
  - S_GREEN=5: 100/100/100/001
  - S_YEL=6: 100/100/100/010
  - ALL_RED2=7: 100/100/100/100
  - FLASH=8: M1, M2 = 010 or 000; MT, S = 100 or 000
- Lights are registered: they change on the same clk edge as the state register, with no combinational path from inputs to lights.
- Timing:
  - On entry to a state, remain loads T_state-1.
  - On a tick cycle with remain≠0, remain decrements.
  - On a tick cycle with remain==0, the state transitions.
  - Non-tick cycles hold everything.
  - A state therefore lasts exactly T ticks.
- Fixed transitions: M_GREEN→M2_YEL→MT_GREEN→MT_YEL→ALL_RED1.
- ALL_RED1 exit, priority order:
  1. flash_req=1 → FLASH
  2. s_pend=1 → S_GREEN
  3. otherwise → M_GREEN (side phase skipped)
- S_GREEN→S_YEL→ALL_RED2.
- ALL_RED2 exit: flash_req=1 → FLASH, otherwise → M_GREEN.
- flash_req is honoured only at all-red exits. A green or yellow phase is never cut short.
- FLASH:
  - The toggle starts at 1 (lamps lit) on entry and inverts on every tick.
  - 1 = lit pattern; 0 = all 000.
  - remain is held at 0.
  - On a tick with flash_req=0 → ALL_RED2 with a full T_ALLRED before M_GREEN.
- s_pend:
  - Set on any clk with s_req=1, in any state except S_GREEN and S_YEL.
  - Cleared on the edge that enters S_GREEN; a request arriving during S_GREEN/S_YEL is not latched.
  - If the set and the S_GREEN entry happen on the same edge, the clear wins.
- Conflicting greens never occur. M2, MT and S are mutually exclusive green; S green implies all mains red.
- Any default or illegal state → ALL_RED2 on the next clk, lamps 100.
- rst_n asserted mid-phase forces the reset values immediately, with no wait for clk.

Test Plan:
- rst_n low 3 clk then high, tick=1 every clk, s_req=0, flash_req=0:
  - all lights 100 for 1 clk, then M_GREEN for 7 clk, M2_YEL 2, MT_GREEN 5, MT_YEL 2, ALL_RED1 1, then back to M_GREEN.
  - Cycle length 17 clk; S never green.
- As above, with a 1-clk s_req pulse during MT_GREEN:
  - s_pend=1 until S_GREEN entry.
  - Sequence adds S_GREEN 3, S_YEL 2, ALL_RED2 1 (23-clk cycle).
  - light_S=001 only while M1/M2/MT=100.
- tick asserted every 4th clk: M_GREEN lasts 28 clk, and remain steps 6,5,…,0 on tick cycles only.
- flash_req raised mid-M_GREEN:
  - Phase sequence completes normally through ALL_RED1, then FLASH: M1=010, S=100, then 000 on the next tick, alternating.
  - Drop flash_req → ALL_RED2 1 tick → M_GREEN.
- rst_n pulsed low asynchronously between clk edges during S_GREEN: lights go 100 immediately and s_pend=0; after release the sequence restarts from ALL_RED2.
- Exhaustive random tick/s_req/flash_req for 10k clk, with checks:
  - no two of M2/MT/S green at once
  - every green is followed by yellow
  - every state lasts exactly T ticks
